memory_access: RTL



---
 rtl/memory_access_pkg.sv | 23 ++
 rtl/memory_access_mem_align.sv | 81 ++++++++
 rtl/memory_access.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_access_pkg.sv
// memory_access_pkg
// Shared definitions for the memory-access pipeline stage: FSM state
// encoding, mem_op encodings and the default bus-timeout limit.
package memory_access_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LBU = 3'd1;
    localparam logic [2:0] OP_LH  = 3'd2;
    localparam logic [2:0] OP_LHU = 3'd3;
    localparam logic [2:0] OP_LW  = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;

    localparam int WAIT_LIMIT_DEF = 16;

endpackage

// File: rtl/memory_access_mem_align.sv
// mem_align
// Purely combinational lane logic for the memory-access stage.
// Ports:
//   addr_lo   in  2   low address bits of the access
//   op        in  3   mem_op encoding
//   sd        in  32  store data (rt)
//   rdata     in  32  raw read data from the data bus
//   be        out 4   byte enables (all ones for loads)
//   wdata     out 32  lane-replicated store data
//   misalign  out 1   access not naturally aligned for its size
//   load_data out 32  extracted and sign/zero-extended load value
module mem_align
    import memory_access_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  op,
    input  logic [31:0] sd,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misalign,
    output logic [31:0] load_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the byte and halfword lanes addressed by addr_lo.
    always_comb begin
        byte_s = rdata[7:0];
        case (addr_lo)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = rdata[7:0];
        endcase
        half_s = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    // Per-op enables, store replication, alignment and load extension.
    always_comb begin
        be        = 4'b1111;
        wdata     = 32'd0;
        misalign  = 1'b0;
        load_data = rdata;
        case (op)
            OP_LB:  load_data = {{24{byte_s[7]}}, byte_s};
            OP_LBU: load_data = {24'd0, byte_s};
            OP_LH: begin
                misalign  = addr_lo[0];
                load_data = {{16{half_s[15]}}, half_s};
            end
            OP_LHU: begin
                misalign  = addr_lo[0];
                load_data = {16'd0, half_s};
            end
            OP_LW:  misalign = (addr_lo != 2'b00);
            OP_SB: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{sd[7:0]}};
            end
            OP_SH: begin
                be       = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata    = {2{sd[15:0]}};
                misalign = addr_lo[0];
            end
            OP_SW: begin
                be       = 4'b1111;
                wdata    = sd;
                misalign = (addr_lo != 2'b00);
            end
            default: begin
                be       = 4'b1111;
                wdata    = 32'd0;
                misalign = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// memory_access
// Pipeline stage after execute. Performs aligned byte/half/word loads and
// stores over a req/addr_ok/data_ok SRAM-style bus and hands a registered,
// single-cycle result to writeback. Detects misalignment and bus timeout.
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   flush                     kill current/incoming op
//   in_valid/in_ready         handshake from execute (ready == IDLE)
//   alu_result, store_data    effective address (or result), store data
//   mem_op, mem_read, mem_write, mem_to_reg, write_reg, reg_write, inst_in
//   data_req/wr/be/addr/wdata bus request side (registered, held in REQ)
//   data_addr_ok, data_rdata, data_data_ok   bus response side
//   wb_valid/wdata/waddr/wen/inst            writeback result pulse
//   exc_adel, exc_ades, badvaddr, bus_err    exception reporting
module memory_access
    import memory_access_pkg::*;
#(
    parameter int WAIT_LIMIT = WAIT_LIMIT_DEF,
    parameter int CNT_W      = 5
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [2:0]  mem_op,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_to_reg,
    input  logic [4:0]  write_reg,
    input  logic        reg_write,
    input  logic [31:0] inst_in,
    output logic        data_req,
    output logic        data_wr,
    output logic [3:0]  data_be,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic [31:0] data_rdata,
    input  logic        data_data_ok,
    output logic        wb_valid,
    output logic [31:0] wb_wdata,
    output logic [4:0]  wb_waddr,
    output logic        wb_wen,
    output logic [31:0] wb_inst,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic [31:0] badvaddr,
    output logic        bus_err
);

    state_e             state_r, state_nxt_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
    logic               killed_r, killed_nxt_s;

    logic [31:0]        addr_r;
    logic [2:0]         mem_op_r;
    logic               m2r_r;
    logic [4:0]         wreg_r;
    logic               rw_r;
    logic [31:0]        inst_r;

    logic               accept_s, is_mem_s, timeout_s, drop_s;
    logic [1:0]         al_addr_s;
    logic [2:0]         al_op_s;
    logic [3:0]         be_s;
    logic [31:0]        wdata_s, load_data_s;
    logic               misalign_s;

    logic               req_nxt_s, wr_nxt_s;
    logic [3:0]         be_nxt_s;
    logic [31:0]        addr_nxt_s, wdata_nxt_s;

    logic               wbv_nxt_s, wen_nxt_s, adel_nxt_s, ades_nxt_s, berr_nxt_s;
    logic [31:0]        wbd_nxt_s, inst_nxt_s, badv_nxt_s;
    logic [4:0]         waddr_nxt_s;

    assign in_ready = (state_r == ST_IDLE);
    assign accept_s = in_valid & (state_r == ST_IDLE) & ~flush;
    assign is_mem_s = mem_read | mem_write;
    // Timeout fires on the cycle the counter would reach WAIT_LIMIT; a
    // data_ok in that same cycle takes priority.
    assign timeout_s = (state_r == ST_WAIT) && (cnt_r == CNT_W'(WAIT_LIMIT - 1)) && !data_data_ok;
    assign drop_s   = flush | killed_r;

    // While IDLE the lane logic looks at the incoming op; otherwise at the latched one.
    assign al_addr_s = (state_r == ST_IDLE) ? alu_result[1:0] : addr_r[1:0];
    assign al_op_s   = (state_r == ST_IDLE) ? mem_op : mem_op_r;

    mem_align u_align (
        .addr_lo   (al_addr_s),
        .op        (al_op_s),
        .sd        (store_data),
        .rdata     (data_rdata),
        .be        (be_s),
        .wdata     (wdata_s),
        .misalign  (misalign_s),
        .load_data (load_data_s)
    );

    // Next-state, wait counter and kill tracking.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = {CNT_W{1'b0}};
        killed_nxt_s = killed_r;
        case (state_r)
            ST_IDLE: begin
                killed_nxt_s = 1'b0;
                if (accept_s && is_mem_s && !misalign_s) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (data_addr_ok) begin
                    // A flush here cannot retract the request: wait it out.
                    state_nxt_s  = ST_WAIT;
                    killed_nxt_s = flush;
                end else if (flush) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (data_data_ok || timeout_s) begin
                    state_nxt_s  = ST_IDLE;
                    killed_nxt_s = 1'b0;
                end else begin
                    state_nxt_s  = ST_WAIT;
                    cnt_nxt_s    = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    killed_nxt_s = killed_r | flush;
                end
            end
            default: begin
                state_nxt_s  = ST_IDLE;
                killed_nxt_s = 1'b0;
            end
        endcase
    end

    // Bus request fields: loaded on entry to REQ, held through REQ, zero otherwise.
    always_comb begin
        req_nxt_s   = (state_nxt_s == ST_REQ);
        wr_nxt_s    = 1'b0;
        be_nxt_s    = 4'b0000;
        addr_nxt_s  = 32'd0;
        wdata_nxt_s = 32'd0;
        if (state_r == ST_IDLE && state_nxt_s == ST_REQ) begin
            wr_nxt_s    = mem_write;
            be_nxt_s    = be_s;
            addr_nxt_s  = {alu_result[31:2], 2'b00};
            wdata_nxt_s = mem_write ? wdata_s : 32'd0;
        end else if (state_r == ST_REQ && state_nxt_s == ST_REQ) begin
            wr_nxt_s    = data_wr;
            be_nxt_s    = data_be;
            addr_nxt_s  = data_addr;
            wdata_nxt_s = data_wdata;
        end else begin
            wr_nxt_s    = 1'b0;
        end
    end

    // Writeback result for the next cycle; everything zero unless a pulse is due.
    always_comb begin
        wbv_nxt_s   = 1'b0;
        wbd_nxt_s   = 32'd0;
        waddr_nxt_s = 5'd0;
        wen_nxt_s   = 1'b0;
        inst_nxt_s  = 32'd0;
        adel_nxt_s  = 1'b0;
        ades_nxt_s  = 1'b0;
        badv_nxt_s  = 32'd0;
        berr_nxt_s  = 1'b0;
        if (accept_s && !is_mem_s) begin
            wbv_nxt_s   = 1'b1;
            wbd_nxt_s   = alu_result;
            waddr_nxt_s = write_reg;
            wen_nxt_s   = reg_write;
            inst_nxt_s  = inst_in;
        end else if (accept_s && misalign_s) begin
            wbv_nxt_s   = 1'b1;
            wbd_nxt_s   = alu_result;
            waddr_nxt_s = write_reg;
            inst_nxt_s  = inst_in;
            adel_nxt_s  = mem_read;
            ades_nxt_s  = mem_write & ~mem_read;
            badv_nxt_s  = alu_result;
        end else if (state_r == ST_WAIT && !drop_s && data_data_ok) begin
            wbv_nxt_s   = 1'b1;
            wbd_nxt_s   = m2r_r ? load_data_s : addr_r;
            waddr_nxt_s = wreg_r;
            wen_nxt_s   = rw_r;
            inst_nxt_s  = inst_r;
        end else if (!drop_s && timeout_s) begin
            wbv_nxt_s   = 1'b1;
            berr_nxt_s  = 1'b1;
            waddr_nxt_s = wreg_r;
            inst_nxt_s  = inst_r;
        end else begin
            wbv_nxt_s   = 1'b0;
        end
    end

    // FSM state, wait counter and kill flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            killed_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            killed_r <= killed_nxt_s;
        end
    end

    // Latch the accepted op's writeback and extraction context.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_r   <= 32'd0;
            mem_op_r <= 3'd0;
            m2r_r    <= 1'b0;
            wreg_r   <= 5'd0;
            rw_r     <= 1'b0;
            inst_r   <= 32'd0;
        end else if (accept_s) begin
            addr_r   <= alu_result;
            mem_op_r <= mem_op;
            m2r_r    <= mem_to_reg;
            wreg_r   <= write_reg;
            rw_r     <= reg_write;
            inst_r   <= inst_in;
        end else begin
            addr_r   <= addr_r;
        end
    end

    // Registered bus request outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_req   <= 1'b0;
            data_wr    <= 1'b0;
            data_be    <= 4'b0000;
            data_addr  <= 32'd0;
            data_wdata <= 32'd0;
        end else begin
            data_req   <= req_nxt_s;
            data_wr    <= wr_nxt_s;
            data_be    <= be_nxt_s;
            data_addr  <= addr_nxt_s;
            data_wdata <= wdata_nxt_s;
        end
    end

    // Registered writeback and exception outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wb_valid <= 1'b0;
            wb_wdata <= 32'd0;
            wb_waddr <= 5'd0;
            wb_wen   <= 1'b0;
            wb_inst  <= 32'd0;
            exc_adel <= 1'b0;
            exc_ades <= 1'b0;
            badvaddr <= 32'd0;
            bus_err  <= 1'b0;
        end else begin
            wb_valid <= wbv_nxt_s;
            wb_wdata <= wbd_nxt_s;
            wb_waddr <= waddr_nxt_s;
            wb_wen   <= wen_nxt_s;
            wb_inst  <= inst_nxt_s;
            exc_adel <= adel_nxt_s;
            exc_ades <= ades_nxt_s;
            badvaddr <= badv_nxt_s;
            bus_err  <= berr_nxt_s;
        end
    end

endmodule
